// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between the MEM stage and a byte-addressed data memory.
// One request at a time: decode/check in IDLE, access in MEM, hold response in RESP.
module lsu_dmem_ctrl #(
    parameter int unsigned WIDTH_ADDR_LENGTH = 32,
    parameter int unsigned WIDTH_DATA_LENGTH = 32,
    parameter int unsigned MEM_DEPTH         = 1 << 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_store,
    input  logic [2:0]                   req_funct3,
    input  logic [WIDTH_ADDR_LENGTH-1:0] req_addr,
    input  logic [WIDTH_DATA_LENGTH-1:0] req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [WIDTH_DATA_LENGTH-1:0] rsp_rdata,
    output logic [1:0]                   rsp_err,
    output logic [WIDTH_ADDR_LENGTH-1:0] dmem_addr,
    output logic [WIDTH_DATA_LENGTH-1:0] dmem_wdata,
    output logic                         dmem_we,
    output logic [1:0]                   dmem_len,
    input  logic [WIDTH_DATA_LENGTH-1:0] dmem_rdata
);

    localparam int unsigned AW1 = WIDTH_ADDR_LENGTH + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEM  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    logic [1:0]                   state_q, state_d;
    logic                         store_q, store_d;
    logic [2:0]                   funct3_q, funct3_d;
    logic [WIDTH_ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [WIDTH_DATA_LENGTH-1:0] wdata_q, wdata_d;
    logic [WIDTH_DATA_LENGTH-1:0] rdata_q, rdata_d;
    logic [1:0]                   err_q, err_d;

    logic                         req_illegal;
    logic                         req_misaligned;
    logic                         req_out_of_range;
    logic [2:0]                   req_size;
    logic [AW1-1:0]               req_end;
    logic [1:0]                   req_err;
    logic [WIDTH_DATA_LENGTH-1:0] load_ext;

    // Request checks on the live inputs, evaluated while IDLE
    always_comb begin
        req_illegal    = req_store ? (req_funct3 > 3'b010)
                                   : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        req_misaligned = 1'b0;
        req_size       = 3'd4;
        case (req_funct3[1:0])
            2'b00: req_size = 3'd1;
            2'b01: begin
                req_size       = 3'd2;
                req_misaligned = req_addr[0];
            end
            default: begin
                req_size       = 3'd4;
                req_misaligned = (req_addr[1:0] != 2'b00);
            end
        endcase
        // One extra bit so an access near the top of the address space cannot wrap
        req_end          = {1'b0, req_addr} + AW1'(req_size);
        req_out_of_range = (req_end > AW1'(MEM_DEPTH));
        if (req_illegal) begin
            req_err = ERR_ILLEGAL;
        end else if (req_misaligned) begin
            req_err = ERR_ALIGN;
        end else if (req_out_of_range) begin
            req_err = ERR_RANGE;
        end else begin
            req_err = ERR_OK;
        end
    end

    always_comb begin
        load_ext = dmem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{(WIDTH_DATA_LENGTH-8){dmem_rdata[7]}}, dmem_rdata[7:0]};
            3'b001:  load_ext = {{(WIDTH_DATA_LENGTH-16){dmem_rdata[15]}}, dmem_rdata[15:0]};
            3'b100:  load_ext = {{(WIDTH_DATA_LENGTH-8){1'b0}}, dmem_rdata[7:0]};
            3'b101:  load_ext = {{(WIDTH_DATA_LENGTH-16){1'b0}}, dmem_rdata[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_err;
                    rdata_d  = '0;
                    state_d  = (req_err == ERR_OK) ? MEM : RESP;
                end
            end
            MEM: begin
                rdata_d = store_q ? '0 : load_ext;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    // Decoded from state so an asynchronous reset kills a pending write at once
    assign dmem_we    = (state_q == MEM) && store_q;
    assign dmem_len   = (funct3_q[1:0] == 2'b10) ? 2'b11 : funct3_q[1:0];

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl with a behavioural byte memory.
// Directed requests push expected responses; a monitor pops them on each handshake.
module tb_lsu_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [1:0]  dmem_len;
    logic [31:0] dmem_rdata;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   we_cnt = 0;

    logic [7:0] mem [0:1023];

    lsu_dmem_ctrl #(
        .WIDTH_ADDR_LENGTH(32),
        .WIDTH_DATA_LENGTH(32),
        .MEM_DEPTH        (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_we   (dmem_we),
        .dmem_len  (dmem_len),
        .dmem_rdata(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        return (a < 32'd1024) ? mem[a[9:0]] : 8'h00;
    endfunction

    always_comb begin
        dmem_rdata = {rd_byte(dmem_addr + 32'd3), rd_byte(dmem_addr + 32'd2),
                      rd_byte(dmem_addr + 32'd1), rd_byte(dmem_addr)};
    end

    // Memory writes on the clock edge; out-of-range bytes are dropped
    always @(posedge clk) begin
        if (dmem_we && !rst) begin
            if (dmem_addr < 32'd1024) mem[dmem_addr[9:0]] <= dmem_wdata[7:0];
            if (dmem_len != 2'b00 && dmem_addr + 32'd1 < 32'd1024)
                mem[dmem_addr[9:0] + 10'd1] <= dmem_wdata[15:8];
            if (dmem_len == 2'b11 && dmem_addr + 32'd3 < 32'd1024) begin
                mem[dmem_addr[9:0] + 10'd2] <= dmem_wdata[23:16];
                mem[dmem_addr[9:0] + 10'd3] <= dmem_wdata[31:24];
            end
        end
    end

    always @(negedge clk) begin
        if (dmem_we) we_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is compared against the oldest expectation
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
            end
        end
    end

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] erd,
                          input logic [1:0] eerr, input bit hold);
        int   lat;
        int   we0;
        rsp_t e;
        logic [1:0] elen;
        elen = (f3[1:0] == 2'b10) ? 2'b11 : f3[1:0];
        rsp_ready = !hold;
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        e.rdata = erd;
        e.err   = eerr;
        exp_q.push_back(e);
        we0 = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (eerr == 2'b00) begin
            check("dmem_addr", dmem_addr, a);
            check("dmem_len", {30'd0, dmem_len}, {30'd0, elen});
            check("dmem_we_mem", {31'd0, dmem_we}, {31'd0, st});
        end
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, (eerr == 2'b00) ? 32'd2 : 32'd1);
        if (hold) begin
            repeat (5) begin
                @(posedge clk);
                #1;
                check("hold_valid", {31'd0, rsp_valid}, 32'd1);
                check("hold_rdata", rsp_rdata, erd);
                check("hold_err", {30'd0, rsp_err}, {30'd0, eerr});
                check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("back_to_idle_valid", {31'd0, rsp_valid}, 32'd0);
        check("back_to_idle_ready", {31'd0, req_ready}, 32'd1);
        check("we_pulses", we_cnt - we0, (st && eerr == 2'b00) ? 32'd1 : 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
        check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        check("rst_dmem_len", {30'd0, dmem_len}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Word store then load-back and extensions
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 1'b0);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 2'b00, 1'b0);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 2'b00, 1'b0);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 2'b00, 1'b0);
        do_req(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 2'b00, 1'b0);

        // Misalignment: never reaches memory
        do_req(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 2'b01, 1'b0);
        do_req(1'b1, 3'b001, 32'h11, 32'hFFFF1234, 32'h0, 2'b01, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 1'b0);

        // Top of memory: misaligned beats range, exact fit is legal
        do_req(1'b0, 3'b010, 32'h3FE, 32'h0, 32'h0, 2'b01, 1'b0);
        do_req(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 2'b10, 1'b0);
        do_req(1'b1, 3'b000, 32'h400, 32'h77, 32'h0, 2'b10, 1'b0);
        do_req(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 2'b10, 1'b0);
        do_req(1'b1, 3'b000, 32'h3FF, 32'h5A, 32'h0, 2'b00, 1'b0);
        do_req(1'b0, 3'b100, 32'h3FF, 32'h0, 32'h0000005A, 2'b00, 1'b0);
        do_req(1'b0, 3'b000, 32'h3FF, 32'h0, 32'h0000005A, 2'b00, 1'b0);

        // Illegal funct3 outranks misalignment and range
        do_req(1'b0, 3'b011, 32'h3FF, 32'h0, 32'h0, 2'b11, 1'b0);
        do_req(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 2'b11, 1'b0);
        do_req(1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 2'b11, 1'b0);

        // Backpressure on the response
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 2'b00, 1'b1);

        // Reset in the middle of a store's MEM cycle
        do_req(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_store = 1'b0;
        check("mid_mem_we", {31'd0, dmem_we}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 2'b00, 1'b0);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
